switch_conditioner: RTL and testbench

SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

---
 rtl/switch_conditioner.sv | 146 ++++++++++++++
 tb/tb_switch_conditioner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_conditioner.sv
// switch_conditioner: synchronise, debounce and handshake-capture
// an 8-bit switch bank plus a strobe switch for a processor port.
module switch_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [8:0] RawSW,
  output logic [8:0] SW,
  output logic       HsRise,
  output logic       DataStable
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    HELD
  } state_e;

  logic [8:0]  sync_q [SYNC_STAGES];
  logic [8:0]  sync_d [SYNC_STAGES];
  logic [7:0]  dat_s;
  logic        hs_s;
  logic [7:0]  dat_prev_q, dat_prev_d;
  logic        hs_prev_q, hs_prev_d;
  logic [15:0] dat_cnt_q, dat_cnt_d;
  logic [15:0] hs_cnt_q, hs_cnt_d;
  logic [7:0]  dat_acc_q, dat_acc_d;
  logic        hs_acc_q, hs_acc_d;
  state_e      state_q;
  logic [7:0]  sw_dat_q;
  logic        sw_hs_q;
  logic        hs_rise_q;

  assign dat_s = sync_q[SYNC_STAGES-1][7:0];
  assign hs_s  = sync_q[SYNC_STAGES-1][8];

  // Shift raw switches through the synchroniser chain
  always_comb begin
    sync_d[0] = RawSW;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Data group: count stable cycles of a new value, accept on the last
  always_comb begin
    dat_prev_d = dat_s;
    dat_cnt_d  = dat_cnt_q;
    dat_acc_d  = dat_acc_q;
    if (dat_s == dat_acc_q) begin
      dat_cnt_d = '0;
    end else if (dat_cnt_q != '0 && dat_s != dat_prev_q) begin
      dat_cnt_d = 16'd1;
    end else if (dat_cnt_q == CNT_LAST) begin
      dat_acc_d = dat_s;
      dat_cnt_d = '0;
    end else begin
      dat_cnt_d = dat_cnt_q + 16'd1;
    end
  end

  // Handshake bit: same filter with its own counter
  always_comb begin
    hs_prev_d = hs_s;
    hs_cnt_d  = hs_cnt_q;
    hs_acc_d  = hs_acc_q;
    if (hs_s == hs_acc_q) begin
      hs_cnt_d = '0;
    end else if (hs_cnt_q != '0 && hs_s != hs_prev_q) begin
      hs_cnt_d = 16'd1;
    end else if (hs_cnt_q == CNT_LAST) begin
      hs_acc_d = hs_s;
      hs_cnt_d = '0;
    end else begin
      hs_cnt_d = hs_cnt_q + 16'd1;
    end
  end

  // Synchroniser and debounce state registers
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      dat_prev_q <= '0;
      hs_prev_q  <= 1'b0;
      dat_cnt_q  <= '0;
      hs_cnt_q   <= '0;
      dat_acc_q  <= '0;
      hs_acc_q   <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      dat_prev_q <= dat_prev_d;
      hs_prev_q  <= hs_prev_d;
      dat_cnt_q  <= dat_cnt_d;
      hs_cnt_q   <= hs_cnt_d;
      dat_acc_q  <= dat_acc_d;
      hs_acc_q   <= hs_acc_d;
    end
  end

  // Capture FSM: track data while idle, freeze it on handshake press
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q   <= IDLE;
      sw_dat_q  <= '0;
      sw_hs_q   <= 1'b0;
      hs_rise_q <= 1'b0;
    end else begin
      sw_hs_q   <= hs_acc_q;
      hs_rise_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          sw_dat_q <= dat_acc_d;
          if (hs_acc_d && !hs_acc_q) begin
            state_q   <= CAPTURE;
            hs_rise_q <= 1'b1;
          end
        end
        CAPTURE: begin
          state_q <= HELD;
        end
        HELD: begin
          if (!hs_acc_q) begin
            state_q  <= IDLE;
            sw_dat_q <= dat_acc_d;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign SW         = {sw_hs_q, sw_dat_q};
  assign HsRise     = hs_rise_q;
  assign DataStable = (dat_cnt_q == '0) && (dat_s == dat_acc_q);

endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed scenarios plus random switch
// activity, checked against a sliding-window reference model.
module tb_switch_conditioner;

  localparam int S = 2;
  localparam int D = 4;

  logic       Clock;
  logic       nReset;
  logic [8:0] RawSW;
  logic [8:0] SW;
  logic       HsRise;
  logic       DataStable;

  int n_chk;
  int n_pass;

  logic [8:0] pipe [$];
  logic [8:0] win  [$];
  logic [7:0] m_acc_d;
  logic       m_acc_h;
  logic [7:0] m_swd;
  logic       m_swh;
  logic       m_rise;
  logic       m_ds;
  int         m_mode;

  switch_conditioner #(
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .Clock(Clock),
    .nReset(nReset),
    .RawSW(RawSW),
    .SW(SW),
    .HsRise(HsRise),
    .DataStable(DataStable)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [8:0] obs,
                     input logic [8:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    pipe.delete();
    win.delete();
    for (int i = 0; i < S; i++) pipe.push_back(9'h000);
    for (int i = 0; i < D; i++) win.push_back(9'h000);
    m_acc_d = '0;
    m_acc_h = 1'b0;
    m_swd   = '0;
    m_swh   = 1'b0;
    m_rise  = 1'b0;
    m_ds    = 1'b1;
    m_mode  = 0;
  endtask

  // A value is accepted once the synced input has shown it for D
  // consecutive cycles while it differs from the accepted value.
  task automatic model_step();
    logic       old_h;
    logic       drun;
    logic       hrun;
    logic [8:0] s_new;
    logic [8:0] s_old;
    if (!nReset) begin
      model_reset();
      return;
    end
    old_h = m_acc_h;
    drun  = 1'b1;
    hrun  = 1'b1;
    for (int i = 1; i < D; i++) begin
      if (win[i][7:0] != win[0][7:0]) drun = 1'b0;
      if (win[i][8] != win[0][8]) hrun = 1'b0;
    end
    if (drun && win[0][7:0] != m_acc_d) m_acc_d = win[0][7:0];
    if (hrun && win[0][8] != m_acc_h) m_acc_h = win[0][8];
    s_old = win[D-1];
    pipe.push_back(RawSW);
    pipe.delete(0);
    s_new = pipe[0];
    win.push_back(s_new);
    win.delete(0);
    m_ds   = (s_new[7:0] == m_acc_d) && (s_old[7:0] == m_acc_d);
    m_swh  = old_h;
    m_rise = 1'b0;
    case (m_mode)
      0: begin
        m_swd = m_acc_d;
        if (m_acc_h && !old_h) begin
          m_mode = 1;
          m_rise = 1'b1;
        end
      end
      1: m_mode = 2;
      default: begin
        if (!old_h) begin
          m_mode = 0;
          m_swd  = m_acc_d;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge Clock);
    model_step();
    #1;
    chk("model_sw", SW, {m_swh, m_swd});
    chk("model_rise", {8'h00, HsRise}, {8'h00, m_rise});
    chk("model_ds", {8'h00, DataStable}, {8'h00, m_ds});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    model_reset();
    nReset = 1'b0;
    RawSW  = 9'h000;
    ticks(2);
    chk("rst_sw", SW, 9'h000);
    chk("rst_rise", {8'h00, HsRise}, 9'h000);
    chk("rst_ds", {8'h00, DataStable}, 9'h001);

    // first acceptance after reset release
    RawSW = 9'h0A5;
    tick();
    nReset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("lat_sw", {1'b0, SW[7:0]}, (k < 6) ? 9'h000 : 9'h0A5);
      chk("lat_ds", {8'h00, DataStable},
          (k >= 2 && k < 6) ? 9'h000 : 9'h001);
    end

    // bouncing data never held long enough
    RawSW = 9'h000;
    ticks(10);
    for (int c = 0; c < 30; c++) begin
      RawSW = ((c / 3) % 2 == 1) ? 9'h03C : 9'h000;
      tick();
      chk("bounce_sw", SW, 9'h000);
    end
    for (int k = 4; k <= 6; k++) begin
      tick();
      chk("bounce_end", SW, (k < 6) ? 9'h000 : 9'h03C);
    end

    // clean handshake press, data frozen while held
    RawSW = 9'h012;
    ticks(8);
    chk("hs_pre", SW, 9'h012);
    RawSW = 9'h112;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("hs_rise", {8'h00, HsRise}, (k == 6) ? 9'h001 : 9'h000);
      chk("hs_sw8", {8'h00, SW[8]}, (k == 7) ? 9'h001 : 9'h000);
      if (k == 6) chk("hs_dat", {1'b0, SW[7:0]}, 9'h012);
    end
    RawSW = 9'h134;
    ticks(10);
    chk("held_freeze", SW, 9'h112);
    RawSW = 9'h034;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("release_sw", SW, (k < 7) ? 9'h112 : 9'h034);
      chk("release_rise", {8'h00, HsRise}, 9'h000);
    end

    // short handshake glitch while held is filtered
    RawSW = 9'h134;
    ticks(8);
    chk("glitch_pre", SW, 9'h134);
    RawSW = 9'h034;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) RawSW = 9'h134;
      tick();
      chk("glitch_sw", SW, 9'h134);
      chk("glitch_rise", {8'h00, HsRise}, 9'h000);
    end

    // reset two cycles into the held state
    RawSW = 9'h034;
    ticks(10);
    RawSW = 9'h134;
    ticks(8);
    nReset = 1'b0;
    tick();
    chk("midrst_sw", SW, 9'h000);
    chk("midrst_rise", {8'h00, HsRise}, 9'h000);
    chk("midrst_ds", {8'h00, DataStable}, 9'h001);
    nReset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("postrst_rise", {8'h00, HsRise}, (k == 6) ? 9'h001 : 9'h000);
    end

    // data and handshake change on the same edge
    RawSW = 9'h000;
    ticks(10);
    RawSW = 9'h1FF;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("same_rise", {8'h00, HsRise}, (k == 6) ? 9'h001 : 9'h000);
      chk("same_dat", {1'b0, SW[7:0]}, (k < 6) ? 9'h000 : 9'h0FF);
    end

    // random switch activity with occasional resets
    for (int r = 0; r < 300; r++) begin
      logic [8:0] v;
      int         len;
      v[7:0] = 8'($urandom_range(0, 3) * 85);
      v[8]   = 1'($urandom_range(0, 1));
      len    = $urandom_range(1, 8);
      if ($urandom_range(0, 60) == 0) begin
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
      end
      for (int i = 0; i < len; i++) begin
        RawSW = v;
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
